trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller.
// Holds the machine CSRs (mstatus, mie, mip, mtvec, mepc, mcause, mcycle),
// decides when to take an exception or interrupt, and asks the frontend to
// redirect to the trap handler.
//
// Ports
//   clk, reset         clock; asynchronous active-low reset
//   irq                level interrupt lines, bit i = cause i
//   exc_valid/exc_code committing instruction raised an exception
//   commit_valid/pc    instruction commit strobe and its PC
//   cur_mode           current privilege mode, saved into mstatus.mpp
//   mret               committing instruction is mret
//   csr_we/wa/wd       CSR write port
//   csr_ra/csr_rd      CSR read port (combinational from registers)
//   trap_valid/ready   redirect handshake with the frontend
//   trap_target        handler PC for the redirect
//   mepc_o             current mepc, used by the frontend for mret
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no trap in flight; CSR writes and mret take effect
// ARMED    | interrupt selected, waiting for a commit to attach it to
// REDIRECT | trap captured, holding trap_valid until trap_ready
module trap_ctrl #(
    parameter int XLEN   = 64,
    parameter int NIRQ   = 16,
    parameter int CODE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NIRQ-1:0]   irq,
    input  logic              exc_valid,
    input  logic [CODE_W-1:0] exc_code,
    input  logic              commit_valid,
    input  logic [XLEN-1:0]   commit_pc,
    input  logic [1:0]        cur_mode,
    input  logic              mret,
    input  logic              csr_we,
    input  logic [11:0]       csr_wa,
    input  logic [XLEN-1:0]   csr_wd,
    input  logic [11:0]       csr_ra,
    output logic [XLEN-1:0]   csr_rd,
    output logic              trap_valid,
    input  logic              trap_ready,
    output logic [XLEN-1:0]   trap_target,
    output logic [XLEN-1:0]   mepc_o
);

    localparam int IDX_W = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;
    localparam logic [11:0] A_MCYCLE  = 12'hB00;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_REDIRECT} state_t;

    state_t            state_q, state_d;
    logic              st_mie_q, st_mie_d;
    logic              st_mpie_q, st_mpie_d;
    logic [1:0]        st_mpp_q, st_mpp_d;
    logic [XLEN-1:0]   mie_q, mie_d;
    logic [XLEN-1:0]   mip_q, mip_d;
    logic [XLEN-1:0]   mtvec_q, mtvec_d;
    logic [XLEN-1:0]   mepc_q, mepc_d;
    logic [XLEN-1:0]   mcause_q, mcause_d;
    logic [XLEN-1:0]   mcycle_q, mcycle_d;
    logic [IDX_W-1:0]  irq_idx_q, irq_idx_d;
    logic              trap_valid_q, trap_valid_d;
    logic [XLEN-1:0]   trap_target_q, trap_target_d;

    logic [NIRQ-1:0]   irq_en;
    logic              pending;
    logic [IDX_W-1:0]  sel_idx;
    logic              cap_exc, cap_irq, do_mret, csr_wr;
    logic [XLEN-1:0]   tvec_base;

    assign irq_en    = irq & mie_q[NIRQ-1:0];
    assign pending   = st_mie_q && (|irq_en);
    assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

    // Highest enabled line wins: later iterations overwrite earlier ones.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (irq_en[i]) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        st_mie_d      = st_mie_q;
        st_mpie_d     = st_mpie_q;
        st_mpp_d      = st_mpp_q;
        mie_d         = mie_q;
        mip_d         = {{(XLEN-NIRQ){1'b0}}, irq};
        mtvec_d       = mtvec_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mcycle_d      = mcycle_q + XLEN'(1);
        irq_idx_d     = irq_idx_q;
        trap_valid_d  = trap_valid_q;
        trap_target_d = trap_target_q;
        cap_exc       = 1'b0;
        cap_irq       = 1'b0;
        do_mret       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (exc_valid) begin
                    cap_exc = 1'b1;
                end else if (pending) begin
                    irq_idx_d = sel_idx;
                    state_d   = S_ARMED;
                end else if (mret) begin
                    do_mret = 1'b1;
                end
            end
            S_ARMED: begin
                // A dropped irq line does not cancel: the interrupt was already taken.
                if (exc_valid) begin
                    cap_exc = 1'b1;
                end else if (commit_valid) begin
                    cap_irq = 1'b1;
                end
            end
            S_REDIRECT: begin
                if (trap_ready) begin
                    state_d      = S_IDLE;
                    trap_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The trap owns the CSRs on a capture edge; a write there is lost.
        csr_wr = csr_we && !(cap_exc || cap_irq) && (state_q != S_REDIRECT);
        if (csr_wr) begin
            case (csr_wa)
                A_MSTATUS: begin
                    st_mie_d  = csr_wd[3];
                    st_mpie_d = csr_wd[7];
                    st_mpp_d  = csr_wd[12:11];
                end
                A_MIE:    mie_d    = csr_wd;
                A_MTVEC:  mtvec_d  = csr_wd;
                A_MEPC:   mepc_d   = csr_wd;
                A_MCAUSE: mcause_d = csr_wd;
                A_MCYCLE: mcycle_d = csr_wd;
                default: ;
            endcase
        end

        if (do_mret) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
            st_mpp_d  = 2'b00;
        end

        if (cap_exc || cap_irq) begin
            mepc_d       = commit_pc;
            st_mpie_d    = st_mie_q;
            st_mie_d     = 1'b0;
            st_mpp_d     = cur_mode;
            state_d      = S_REDIRECT;
            trap_valid_d = 1'b1;
            if (cap_irq) begin
                mcause_d = {1'b1, {(XLEN-1-IDX_W){1'b0}}, irq_idx_q};
                trap_target_d = (mtvec_q[1:0] == 2'b01)
                              ? tvec_base + {{(XLEN-IDX_W-2){1'b0}}, irq_idx_q, 2'b00}
                              : tvec_base;
            end else begin
                mcause_d      = {{(XLEN-CODE_W){1'b0}}, exc_code};
                trap_target_d = tvec_base;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            st_mie_q      <= 1'b0;
            st_mpie_q     <= 1'b0;
            st_mpp_q      <= 2'b00;
            mie_q         <= '0;
            mip_q         <= '0;
            mtvec_q       <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mcycle_q      <= '0;
            irq_idx_q     <= '0;
            trap_valid_q  <= 1'b0;
            trap_target_q <= '0;
        end else begin
            state_q       <= state_d;
            st_mie_q      <= st_mie_d;
            st_mpie_q     <= st_mpie_d;
            st_mpp_q      <= st_mpp_d;
            mie_q         <= mie_d;
            mip_q         <= mip_d;
            mtvec_q       <= mtvec_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mcycle_q      <= mcycle_d;
            irq_idx_q     <= irq_idx_d;
            trap_valid_q  <= trap_valid_d;
            trap_target_q <= trap_target_d;
        end
    end

    always_comb begin
        csr_rd = '0;
        case (csr_ra)
            A_MSTATUS: begin
                csr_rd[3]     = st_mie_q;
                csr_rd[7]     = st_mpie_q;
                csr_rd[12:11] = st_mpp_q;
            end
            A_MIE:    csr_rd = mie_q;
            A_MIP:    csr_rd = mip_q;
            A_MTVEC:  csr_rd = mtvec_q;
            A_MEPC:   csr_rd = mepc_q;
            A_MCAUSE: csr_rd = mcause_q;
            A_MCYCLE: csr_rd = mcycle_q;
            default:  csr_rd = '0;
        endcase
    end

    assign trap_valid  = trap_valid_q;
    assign trap_target = trap_target_q;
    assign mepc_o      = mepc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
    localparam int XLEN = 64;
    localparam int NIRQ = 16;
    localparam int CODE_W = 4;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;

    logic              clk, reset;
    logic [NIRQ-1:0]   irq;
    logic              exc_valid, commit_valid, mret, csr_we, trap_ready;
    logic [CODE_W-1:0] exc_code;
    logic [XLEN-1:0]   commit_pc, csr_wd, csr_rd, trap_target, mepc_o;
    logic [1:0]        cur_mode;
    logic [11:0]       csr_wa, csr_ra;
    logic              trap_valid;

    trap_ctrl #(.XLEN(XLEN), .NIRQ(NIRQ), .CODE_W(CODE_W)) dut (
        .clk(clk), .reset(reset), .irq(irq), .exc_valid(exc_valid), .exc_code(exc_code),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .cur_mode(cur_mode), .mret(mret),
        .csr_we(csr_we), .csr_wa(csr_wa), .csr_wd(csr_wd), .csr_ra(csr_ra), .csr_rd(csr_rd),
        .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_target(trap_target),
        .mepc_o(mepc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard queues
    typedef struct { logic [63:0] target; logic [63:0] epc; } trap_exp_t;
    typedef struct { string name; logic [63:0] val; } rd_exp_t;
    trap_exp_t trap_q[$];
    rd_exp_t   rd_q[$];
    trap_exp_t cur;
    logic      rd_req = 1'b0;
    logic      in_trap = 1'b0;
    logic      expect_low = 1'b0;

    // Reference model: architectural CSR state
    logic        m_mie, m_mpie;
    logic [1:0]  m_mpp;
    logic [63:0] m_mier, m_mtvec, m_mepc, m_mcause;

    task automatic mdl_reset();
        m_mie = 0; m_mpie = 0; m_mpp = 0;
        m_mier = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
    endtask

    function automatic logic [63:0] mdl_read(input logic [11:0] a);
        logic [63:0] v;
        v = '0;
        case (a)
            A_MSTATUS: begin v[3] = m_mie; v[7] = m_mpie; v[12:11] = m_mpp; end
            A_MIE:     v = m_mier;
            A_MTVEC:   v = m_mtvec;
            A_MEPC:    v = m_mepc;
            A_MCAUSE:  v = m_mcause;
            default:   v = '0;
        endcase
        return v;
    endfunction

    function automatic int top_bit(input logic [15:0] v);
        int r = -1;
        for (int i = 0; i < 16; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic mdl_capture(input logic is_irq, input logic [63:0] code,
                               input logic [63:0] pc, input logic [1:0] mode);
        trap_exp_t e;
        logic [63:0] base;
        base = {m_mtvec[63:2], 2'b00};
        e.target = (is_irq && m_mtvec[1:0] == 2'd1) ? base + 4 * code : base;
        e.epc = pc;
        trap_q.push_back(e);
        m_mepc   = pc;
        m_mcause = is_irq ? ((64'd1 << 63) | code) : code;
        m_mpie   = m_mie;
        m_mie    = 1'b0;
        m_mpp    = mode;
    endtask

    // Monitor: pops expected traps and CSR reads, compares against the DUT
    always @(negedge clk) begin
        rd_exp_t r;
        if (reset) begin
            if (rd_req) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rd_underflow: got read strobe expected queued value");
                end else begin
                    r = rd_q.pop_front();
                    check(r.name, csr_rd, r.val);
                end
            end
            if (expect_low) begin
                check("trap_valid_after_ready", 64'(trap_valid), 64'd0);
                expect_low = 1'b0;
            end
            if (trap_valid) begin
                if (!in_trap) begin
                    if (trap_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_trap: got trap_valid=1 expected 0");
                    end else begin
                        cur = trap_q.pop_front();
                        in_trap = 1'b1;
                    end
                end
                if (in_trap) begin
                    check("trap_target", trap_target, cur.target);
                    check("mepc_o", mepc_o, cur.epc);
                    if (trap_ready) begin
                        in_trap = 1'b0;
                        expect_low = 1'b1;
                    end
                end
            end else begin
                in_trap = 1'b0;
            end
        end else begin
            in_trap = 1'b0;
            expect_low = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
        csr_we = 1'b1; csr_wa = a; csr_wd = d;
        tick();
        csr_we = 1'b0;
        case (a)
            A_MSTATUS: begin m_mie = d[3]; m_mpie = d[7]; m_mpp = d[12:11]; end
            A_MIE:     m_mier = d;
            A_MTVEC:   m_mtvec = d;
            A_MEPC:    m_mepc = d;
            A_MCAUSE:  m_mcause = d;
            default: ;
        endcase
    endtask

    task automatic csr_expect(input logic [11:0] a, input string name, input logic [63:0] v);
        rd_exp_t r;
        r.name = name; r.val = v;
        rd_q.push_back(r);
        csr_ra = a; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic csr_check(input logic [11:0] a, input string name);
        csr_expect(a, name, mdl_read(a));
    endtask

    task automatic do_mret();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        m_mie = m_mpie; m_mpie = 1'b1; m_mpp = 2'b00;
    endtask

    // Called right after the capture edge: holds off trap_ready while
    // throwing inputs that must all be ignored, then accepts.
    task automatic finish_trap(input int hold);
        check("trap_raised", 64'(trap_valid), 64'd1);
        repeat (hold) begin
            exc_valid = 1'($urandom_range(0, 1));
            exc_code = 4'($urandom);
            commit_valid = 1'($urandom_range(0, 1));
            commit_pc = {$urandom, $urandom};
            mret = 1'($urandom_range(0, 1));
            csr_we = 1'b1;
            case ($urandom_range(0, 5))
                0: csr_wa = A_MSTATUS;
                1: csr_wa = A_MIE;
                2: csr_wa = A_MTVEC;
                3: csr_wa = A_MEPC;
                4: csr_wa = A_MCAUSE;
                default: csr_wa = A_MSCRATCH;
            endcase
            csr_wd = {$urandom, $urandom};
            tick();
        end
        exc_valid = 0; commit_valid = 0; mret = 0; csr_we = 0;
        trap_ready = 1'b1;
        tick();
        trap_ready = 1'b0;
    endtask

    task automatic do_exception(input logic [3:0] code, input logic [63:0] pc,
                                input logic [1:0] mode, input int hold);
        exc_valid = 1'b1; exc_code = code; commit_pc = pc; cur_mode = mode;
        commit_valid = 1'($urandom_range(0, 1));
        mret = 1'($urandom_range(0, 1));
        csr_we = 1'b1; csr_wa = A_MTVEC; csr_wd = {$urandom, $urandom};
        mdl_capture(1'b0, 64'(code), pc, mode);
        tick();
        exc_valid = 0; commit_valid = 0; mret = 0; csr_we = 0;
        finish_trap(hold);
    endtask

    task automatic do_irq(input logic [15:0] irq_v, input logic [63:0] pc,
                          input logic [1:0] mode, input int wait_cyc, input int hold);
        int cause;
        cause = top_bit(irq_v & m_mier[15:0]);
        irq = irq_v;
        tick();
        repeat (wait_cyc) begin
            mret = 1'($urandom_range(0, 1));
            irq = ($urandom_range(0, 1) == 1) ? irq_v : 16'h0;
            tick();
        end
        mret = 1'b0; irq = irq_v;
        commit_valid = 1'b1; commit_pc = pc; cur_mode = mode;
        csr_we = 1'b1; csr_wa = A_MSTATUS; csr_wd = '0;
        mdl_capture(1'b1, 64'(cause), pc, mode);
        tick();
        commit_valid = 1'b0; csr_we = 1'b0;
        finish_trap(hold);
    endtask

    task automatic check_all(input string tag);
        csr_check(A_MSTATUS, {tag, "_mstatus"});
        csr_check(A_MIE,     {tag, "_mie"});
        csr_check(A_MTVEC,   {tag, "_mtvec"});
        csr_check(A_MEPC,    {tag, "_mepc"});
        csr_check(A_MCAUSE,  {tag, "_mcause"});
        csr_check(A_MIP,     {tag, "_mip"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] iv;
        logic [63:0] mv;
        int b;
        reset = 0; irq = 0; exc_valid = 0; exc_code = 0; commit_valid = 0; commit_pc = 0;
        cur_mode = 0; mret = 0; csr_we = 0; csr_wa = 0; csr_wd = 0; csr_ra = 0; trap_ready = 0;
        mdl_reset();
        repeat (3) @(posedge clk);
        #3 reset = 1;
        check("reset_trap_valid", 64'(trap_valid), 64'd0);
        csr_expect(A_MCYCLE, "reset_mcycle0", 64'd0);
        csr_expect(A_MCYCLE, "reset_mcycle1", 64'd1);
        check_all("reset");

        // Exception with 5 cycles of backpressure
        csr_write(A_MTVEC, 64'h8000_0000);
        csr_write(A_MSTATUS, 64'h8);
        do_exception(4'd2, 64'h100, 2'd3, 5);
        csr_expect(A_MEPC, "exc_mepc", 64'h100);
        csr_expect(A_MCAUSE, "exc_mcause", 64'd2);
        csr_expect(A_MSTATUS, "exc_mstatus", 64'h1880);
        check_all("exc");

        // Vectored interrupt, bits 7 and 11 pending -> cause 11
        csr_write(A_MTVEC, 64'h8000_0001);
        csr_write(A_MIE, 64'h880);
        csr_write(A_MSTATUS, 64'h8);
        do_irq(16'h0880, 64'h200, 2'd0, 2, 1);
        irq = 0;
        csr_expect(A_MCAUSE, "virq_mcause", 64'h8000_0000_0000_000B);
        csr_expect(A_MEPC, "virq_mepc", 64'h200);

        // Exception collides with the armed interrupt; interrupt retaken after mret
        csr_write(A_MIE, 64'h80);
        csr_write(A_MSTATUS, 64'h8);
        irq = 16'h0080;
        tick();
        exc_valid = 1; exc_code = 4'd5; commit_valid = 1; commit_pc = 64'h300; cur_mode = 2'd1;
        mdl_capture(1'b0, 64'd5, 64'h300, 2'd1);
        tick();
        exc_valid = 0; commit_valid = 0;
        finish_trap(2);
        csr_expect(A_MCAUSE, "coll_mcause", 64'd5);
        do_mret();
        csr_check(A_MSTATUS, "coll_mret_mstatus");
        do_irq(16'h0080, 64'h304, 2'd0, 0, 0);
        irq = 0;
        csr_expect(A_MCAUSE, "coll_irq_mcause", 64'h8000_0000_0000_0007);

        // mcycle wrap and mret with mpie=1
        csr_write(A_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_expect(A_MCYCLE, "mcycle_loaded", 64'hFFFF_FFFF_FFFF_FFFF);
        csr_expect(A_MCYCLE, "mcycle_wrap", 64'd0);
        csr_expect(A_MCYCLE, "mcycle_inc", 64'd1);
        csr_write(A_MSTATUS, 64'h1880);
        do_mret();
        csr_expect(A_MSTATUS, "mret_mstatus", 64'h88);

        // mip mirrors irq one cycle later; unmapped address reads zero
        csr_write(A_MSTATUS, 64'h0);
        irq = 16'hA5C3;
        tick();
        csr_expect(A_MIP, "mip_value", 64'hA5C3);
        irq = 0;
        tick();
        csr_write(A_MSCRATCH, 64'h1234_5678);
        csr_expect(A_MSCRATCH, "unmapped_read", 64'd0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    do_exception(4'($urandom), {$urandom, $urandom}, 2'($urandom),
                                 int'($urandom_range(0, 5)));
                end
                1: begin
                    b = int'($urandom_range(0, 15));
                    csr_write(A_MTVEC, {$urandom, $urandom});
                    mv = {$urandom, $urandom} | (64'd1 << b);
                    csr_write(A_MIE, mv);
                    csr_write(A_MSTATUS, {$urandom, $urandom} | 64'h8);
                    iv = 16'($urandom) | (16'd1 << b);
                    do_irq(iv, {$urandom, $urandom}, 2'($urandom),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
                    irq = 0;
                end
                2: do_mret();
                default: begin
                    case ($urandom_range(0, 6))
                        0: csr_wa = A_MSTATUS;
                        1: csr_wa = A_MIE;
                        2: csr_wa = A_MTVEC;
                        3: csr_wa = A_MEPC;
                        4: csr_wa = A_MCAUSE;
                        5: csr_wa = A_MIP;
                        default: csr_wa = A_MSCRATCH;
                    endcase
                    csr_write(csr_wa, {$urandom, $urandom});
                end
            endcase
            check_all("rand");
        end

        // Reset asserted in the middle of REDIRECT
        csr_write(A_MTVEC, 64'h4000);
        exc_valid = 1; exc_code = 4'd7; commit_pc = 64'h880; cur_mode = 2'd3;
        mdl_capture(1'b0, 64'd7, 64'h880, 2'd3);
        tick();
        exc_valid = 0;
        check("rst_pre_trap_valid", 64'(trap_valid), 64'd1);
        @(negedge clk);
        #1 reset = 0;
        #1;
        check("rst_async_trap_valid", 64'(trap_valid), 64'd0);
        check("rst_async_target", trap_target, 64'd0);
        @(posedge clk);
        #3 reset = 1;
        mdl_reset();
        csr_expect(A_MCYCLE, "rst2_mcycle0", 64'd0);
        csr_expect(A_MCYCLE, "rst2_mcycle1", 64'd1);
        check_all("rst2");
        check("rst2_trap_valid", 64'(trap_valid), 64'd0);

        repeat (2) tick();
        check("trap_queue_drained", 64'(trap_q.size()), 64'd0);
        check("read_queue_drained", 64'(rd_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
